// File: rtl/alu_control_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_control_muldiv
// Brief    : RV32IM ALU control decode plus iterative multiply/divide engine.
// Revision : 1.0 - initial release
// ============================================================================
module alu_control_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [6:0]       funct7_i,
  input  logic [2:0]       ALU_Op_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic [3:0]       ALU_Operation_o,
  output logic             illegal_o,
  output logic             md_busy_o,
  output logic             md_done_o,
  output logic [WIDTH-1:0] md_result_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LUI  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_MD   = 4'b1111;

  logic [3:0] dec_op;
  logic       dec_ill;

  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    case (ALU_Op_i)
      3'b000: begin
        if (funct7_i == 7'b0000000) begin
          case (funct3_i)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7_i == 7'b0100000) begin
          if (funct3_i == 3'b000)      dec_op  = OP_SUB;
          else if (funct3_i == 3'b101) dec_op  = OP_SRA;
          else                         dec_ill = 1'b1;
        end else if (funct7_i == 7'b0000001) begin
          dec_op = OP_MD;
        end else begin
          dec_ill = 1'b1;
        end
      end
      3'b001: begin
        case (funct3_i)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: begin
            if (funct7_i == 7'b0000000) dec_op  = OP_SLL;
            else                        dec_ill = 1'b1;
          end
          default: begin
            if (funct7_i == 7'b0000000)      dec_op  = OP_SRL;
            else if (funct7_i == 7'b0100000) dec_op  = OP_SRA;
            else                             dec_ill = 1'b1;
          end
        endcase
      end
      3'b010:  dec_op  = OP_SUB;
      3'b011:  dec_op  = OP_ADD;
      3'b111:  dec_op  = OP_LUI;
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) dec_op = OP_ADD;
  end

  assign ALU_Operation_o = dec_op;
  assign illegal_o       = dec_ill;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [2:0]         md_f3;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;

  logic start;
  logic new_sa, new_sb;
  logic [WIDTH-1:0] new_a_mag, new_b_mag;

  assign start = valid_i && (state == S_IDLE) && (dec_op == OP_MD) && !dec_ill;

  // Only MULHU, DIVU and REMU treat rs1 as unsigned; rs2 is also unsigned for MULHSU.
  always_comb begin
    new_sa    = rs1_i[WIDTH-1] && !(funct3_i == 3'b011 || funct3_i == 3'b101 || funct3_i == 3'b111);
    new_sb    = rs2_i[WIDTH-1] && !(funct3_i == 3'b010 || funct3_i == 3'b011 ||
                                   funct3_i == 3'b101 || funct3_i == 3'b111);
    new_a_mag = new_sa ? -rs1_i : rs1_i;
    new_b_mag = new_sb ? -rs2_i : rs2_i;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;

  // Multiply: multiplier sits in the low half and shifts out as the product
  // shifts in. Divide: remainder in the high half, dividend/quotient below.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    if (!md_f3[2])
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   remd;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   final_res;
  logic               b_zero;

  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc_next : acc_next;
    quot   = acc_next[WIDTH-1:0];
    remd   = acc_next[2*WIDTH-1:WIDTH];
    a_orig = sign_a ? -a_mag : a_mag;
    b_zero = (b_mag == '0);
    case (md_f3)
      3'b000:         final_res = prod[WIDTH-1:0];
      3'b001, 3'b010,
      3'b011:         final_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101: final_res = b_zero ? '1 : ((sign_a ^ sign_b) ? -quot : quot);
      default:        final_res = b_zero ? a_orig : (sign_a ? -remd : remd);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      count       <= '0;
      md_f3       <= 3'b000;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      a_mag       <= '0;
      b_mag       <= '0;
      acc         <= '0;
      md_result_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            count  <= '0;
            md_f3  <= funct3_i;
            sign_a <= new_sa;
            sign_b <= new_sb;
            a_mag  <= new_a_mag;
            b_mag  <= new_b_mag;
            acc    <= {{WIDTH{1'b0}}, (funct3_i[2] ? new_a_mag : new_b_mag)};
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state       <= S_DONE;
            md_result_o <= final_res;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign md_busy_o = (state == S_RUN) || start;
  assign md_done_o = (state == S_DONE);

endmodule
`default_nettype wire
